// File: rtl/fetch_issue.sv
// fetch_issue: instruction-side sequencer, producer end of the instr -> control
// interface. Owns the PC, fetches one word at a time from instruction memory,
// holds it in an instruction register and offers it to decode. A HALT opcode
// stops the sequencer until the next reset.
//
// Handshakes (both directions use the same rule): a transfer happens on a rising
// clock edge where the producer's valid/req and the consumer's ready are both 1.
// The producer keeps its payload (imem_addr / instr) stable until that edge, and
// ready is ignored while valid/req is 0.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_req / imem_addr    fetch request and word address (imem_addr == pc)
//   imem_ready / imem_rdata read data valid / fetched word
//   instr / instr_valid     instruction register and its valid flag to decode
//   instr_ready             decode accepts instr this cycle
//   redirect_valid / _pc    next-PC override, sampled only when instr is accepted
//   halted                  sticky, set when a HALT instruction is accepted
//   pc                      address of the current or last fetched instruction
//   icount [31:0]           accepted-instruction counter (only with the macro)
//
// Optional feature macro: FETCH_ISSUE_ICOUNT_EN adds the icount output.

`ifndef OP_HALT
`define OP_HALT 4'hF
`endif

module fetch_issue #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   halted,
  output logic [ADDR_WIDTH-1:0]  pc
`ifdef FETCH_ISSUE_ICOUNT_EN
  ,
  output logic [31:0]            icount
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic                   fetch_hs;
  logic                   accept;
  logic                   is_halt;

  // Handshakes are qualified by the registered req/valid so a ready that
  // arrives in the cycle right after reset (req still 0) is ignored.
  assign fetch_hs = req_q & imem_ready;
  assign accept   = valid_q & instr_ready;
  assign is_halt  = (instr_q[INSTR_WIDTH-1 -: 4] == `OP_HALT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_hs) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          // HALT takes priority; a simultaneous redirect is dropped.
          if (is_halt) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
            pc_d    = redirect_valid ? redirect_pc : pc_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign pc          = pc_q;

`ifdef FETCH_ISSUE_ICOUNT_EN
  logic [31:0] icount_q, icount_d;

  // accept only occurs in ISSUE, so counting naturally stops in HALT and the
  // HALT instruction itself is counted.
  always_comb begin
    icount_d = icount_q;
    if (accept) begin
      icount_d = icount_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icount_q <= 32'd0;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_fetch_issue.sv
// Testbench for fetch_issue: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.

`ifndef OP_HALT
`define OP_HALT 4'hF
`endif
`ifndef OP_ADD
`define OP_ADD 4'h0
`endif
`ifndef OP_ADDI
`define OP_ADDI 4'h1
`endif

module tb_fetch_issue;

  localparam int IW = 16;
  localparam int AW = 16;
  localparam logic [AW-1:0] RPC = 16'h0000;

  localparam int PH_GAP   = 0;  // cycle right after reset, no request yet
  localparam int PH_FETCH = 1;
  localparam int PH_ISSUE = 2;
  localparam int PH_HALT  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halted;
  logic [AW-1:0] pc;
`ifdef FETCH_ISSUE_ICOUNT_EN
  logic [31:0]   icount;
`endif

  fetch_issue #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .pc            (pc)
`ifdef FETCH_ISSUE_ICOUNT_EN
    ,
    .icount        (icount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [IW-1:0] mem [0:255];   // instruction memory, indexed by pc[7:0]
  int            m_phase;
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_instr;
  logic          m_halted;
  logic [31:0]   m_icount;
  logic [IW-1:0] exp_q[$];      // fetched words awaiting acceptance

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("imem_req",    {31'd0, imem_req},    {31'd0, m_phase == PH_FETCH});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == PH_ISSUE});
    check("halted",      {31'd0, halted},      {31'd0, m_halted});
    check("pc",          {16'd0, pc},          {16'd0, m_pc});
    check("imem_addr",   {16'd0, imem_addr},   {16'd0, m_pc});
    check("instr",       {16'd0, instr},       {16'd0, m_instr});
`ifdef FETCH_ISSUE_ICOUNT_EN
    check("icount",      icount,               m_icount);
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then sample the DUT 1 time unit after that edge.
  task automatic step(input bit rst, input bit rdy, input bit irdy,
                      input bit rv, input logic [AW-1:0] rpc);
    logic [IW-1:0] w;
    rst_n          = !rst;
    imem_ready     = rdy;
    instr_ready    = irdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = IW'($urandom);  // junk unless memory is responding
    if (rst) begin
      m_phase  = PH_GAP;
      m_pc     = RPC;
      m_instr  = '0;
      m_halted = 1'b0;
      m_icount = 32'd0;
      exp_q.delete();
    end else begin
      case (m_phase)
        PH_GAP: m_phase = PH_FETCH;
        PH_FETCH: begin
          if (rdy) begin
            imem_rdata = mem[m_pc[7:0]];
            exp_q.push_back(imem_rdata);
            m_instr = imem_rdata;
            m_phase = PH_ISSUE;
          end
        end
        PH_ISSUE: begin
          if (irdy) begin
            w = exp_q.pop_front();
            check("accept_instr", {16'd0, instr}, {16'd0, w});
            m_icount = m_icount + 32'd1;
            if (w[IW-1 -: 4] == `OP_HALT) begin
              m_phase  = PH_HALT;
              m_halted = 1'b1;
            end else begin
              m_pc    = rv ? rpc : m_pc + 16'd1;
              m_phase = PH_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1, 1, 1, 0, 16'h0);
    step(0, 1, 1, 0, 16'h0);  // ready here must be ignored (no request yet)
  endtask

  task automatic fetch();
    step(0, 1, 0, 0, 16'h0);
  endtask

  task automatic accept(input bit rv, input logic [AW-1:0] rpc);
    step(0, 0, 1, rv, rpc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int halt_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; imem_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = {`OP_ADD, 12'(i)};

    // Reset then idle memory.
    step(1, 0, 0, 0, 16'h0);
    repeat (6) step(0, 0, 0, 0, 16'h0);

    // ADD, ADDI, HALT program with immediate handshakes.
    mem[0] = {`OP_ADD, 12'h000};
    mem[1] = {`OP_ADDI, 12'h005};
    mem[2] = {`OP_HALT, 12'h000};
    do_reset();
    repeat (3) begin
      fetch();
      accept(0, 16'h0);
    end
    repeat (4) step(0, 1, 1, 0, 16'h0);

    // Decode stall: instr/pc must hold, no new request.
    mem[0] = {`OP_ADD, 12'h123};
    do_reset();
    fetch();
    repeat (4) step(0, 1, 0, 1, 16'h0077);
    accept(0, 16'h0);
    fetch();

    // Redirect at pc=3, then the same with a HALT word.
    for (int i = 0; i < 4; i++) mem[i] = {`OP_ADD, 12'(i + 1)};
    mem[8'h40] = {`OP_ADDI, 12'h040};
    do_reset();
    repeat (3) begin
      fetch();
      accept(0, 16'h0);
    end
    fetch();
    accept(1, 16'h0040);
    fetch();
    accept(0, 16'h0);
    mem[3] = {`OP_HALT, 12'h3AB};
    do_reset();
    repeat (3) begin
      fetch();
      accept(0, 16'h0);
    end
    fetch();
    accept(1, 16'h0040);
    repeat (3) step(0, 1, 1, 1, 16'h0040);

    // PC wrap from all-ones.
    mem[0]     = {`OP_ADD, 12'h001};
    mem[8'hFF] = {`OP_ADD, 12'hFFF};
    do_reset();
    fetch();
    accept(1, 16'hFFFF);
    fetch();
    accept(0, 16'h0);
    fetch();

    // Reset while an instruction is being offered.
    do_reset();
    fetch();
    step(1, 1, 1, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);

    // Randomized traffic.
    for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
    do_reset();
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rst;
      halt_cnt = (m_phase == PH_HALT) ? halt_cnt + 1 : 0;
      rst = ($urandom_range(0, 99) == 0) || (halt_cnt > 4);
      step(rst,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0,
           AW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Instruction-side sequencer that produces the instruction stream consumed by the control decoder. It is the producer end of the instr -> control interface.
- Owns the program counter and fetches words from instruction memory over a req/ready handshake.
- Holds each fetched word in an instruction register and presents it to decode with a valid/ready handshake.
- Stops permanently on a HALT opcode.

Parameters:
- INSTR_WIDTH, 16, instruction word width; opcode is instr[INSTR_WIDTH-1 -: 4], compared against `OP_HALT from defs.svh.
- ADDR_WIDTH, 16, word-addressed PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  ADDR_WIDTH  fetch address; always equals pc.
- imem_ready  in  1  read data valid this cycle; ignored unless imem_req=1.
- imem_rdata  in  INSTR_WIDTH  fetched word.
- instr  out  INSTR_WIDTH  instruction register, driven to the control decoder.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect_valid  in  1  next PC override; sampled only on an accept.
- redirect_pc  in  ADDR_WIDTH  override target.
- halted  out  1  HALT instruction has been accepted; sticky.
- pc  out  ADDR_WIDTH  address of the current or last fetched instruction.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state<=FETCH, pc<=RESET_PC, instr<=0, instr_valid<=0, halted<=0.
  - imem_req is 0 while rst_n=0, and 1 from the first cycle after rst_n rises.
- Reset mid-operation: abandons any outstanding fetch or unaccepted instruction. Any imem_ready arriving in the reset cycle is ignored.
- States: FETCH, ISSUE, HALT. imem_req=1 only in FETCH; instr_valid=1 only in ISSUE.
- FETCH:
  - imem_addr=pc and stays stable.
  - On an edge with imem_ready=1: instr<=imem_rdata, state<=ISSUE.
  - Otherwise remain in FETCH. Wait is unbounded; no timeout.
- ISSUE:
  - instr and pc are stable while instr_ready=0.
  - On an edge with instr_ready=1:
    - If the opcode is `OP_HALT: state<=HALT, halted<=1, pc unchanged.
    - Else if redirect_valid=1: pc<=redirect_pc, state<=FETCH.
    - Else: pc<=pc+1, modulo 2^ADDR_WIDTH (all-ones wraps to 0), state<=FETCH.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - instr retains the HALT word.
  - Leaves HALT only through reset.
- Simultaneous HALT opcode and redirect_valid at accept: HALT wins and the redirect is dropped.
- Latency:
  - Minimum 2 cycles per instruction: 1 FETCH cycle with immediate imem_ready, then 1 ISSUE cycle with immediate instr_ready.
  - The instr_valid rising edge is exactly 1 cycle after the imem_ready edge.
- imem_rdata is captured only when imem_req and imem_ready are both high.
- No combinational path from any input to any output except imem_addr=pc, which is registered.

Optional Feature:
- Macro: FETCH_ISSUE_ICOUNT_EN.
- Defined:
  - Adds output icount [31:0], reset to 0.
  - Increments by 1 on every accepted instruction (instr_valid & instr_ready), including the HALT instruction.
  - Wraps at 2^32 and stops counting in HALT.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle memory (imem_ready=0 for 5 cycles) -> imem_req=1, imem_addr=0, instr_valid=0 throughout, halted=0.
- Memory returns {`OP_ADD,12'h0}, {`OP_ADDI,12'h005}, {`OP_HALT,12'h0} with imem_ready=1 every FETCH and instr_ready=1 -> addresses 0,1,2 fetched, each instr_valid 1 cycle after imem_ready, halted=1 after the third accept, imem_req stays 0 afterwards (icount=3 when enabled).
- instr_ready held 0 for 4 cycles in ISSUE -> instr and pc unchanged, no new imem_req; on release, pc increments by exactly 1.
- Accept {`OP_ADD,..} at pc=3 with redirect_valid=1, redirect_pc=16'h0040 -> next imem_addr=16'h0040. Repeat with a HALT word -> halted=1 and no fetch of 0x0040.
- RESET_PC=16'hFFFF, accept a non-HALT instruction -> next imem_addr=16'h0000.
- Assert rst_n=0 for one cycle while in ISSUE with instr_valid=1 -> next cycle instr_valid=0, instr=0, pc=RESET_PC, halted=0. In the following cycle imem_req=1.
